// File: rtl/spi_eeprom_slave.sv
// spi_eeprom_slave: SPI mode-0 responder modelling a 128-byte 25xx-style EEPROM.
// Ports: clk, rst (sync, active-high); sck, csn, mosi (async SPI inputs);
//        miso, miso_oe (SPI outputs); wip, wel (status bits).
module spi_eeprom_slave #(
    parameter int ADDR_W       = 7,
    parameter int WRITE_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic sck,
    input  logic csn,
    input  logic mosi,
    output logic miso,
    output logic miso_oe,
    output logic wip,
    output logic wel
);
    localparam int BW = $clog2(WRITE_CYCLES + 1);

    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, RD, WR, STAT, WAIT_CS, IGNORE
    } state_t;

    logic [7:0] mem [2**ADDR_W];

    logic [2:0] sck_q;
    logic [2:0] csn_q;
    logic [1:0] mosi_q;

    state_t            state_q, state_d;
    logic [4:0]        bitcnt_q, bitcnt_d;
    logic [2:0]        bitpos_q, bitpos_d;
    logic [7:0]        shin_q, shin_d;
    logic [7:0]        out_q, out_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [7:0]        pdata_q, pdata_d;
    logic              rd_q, rd_d;
    logic              wren_q, wren_d;
    logic              skip_q, skip_d;
    logic              reload_q, reload_d;
    logic              wel_q, wel_d;
    logic              wip_q, wip_d;
    logic [BW-1:0]     busy_q, busy_d;
    logic              mem_we;

    logic       sck_rise;
    logic       sck_fall;
    logic       csn_s;
    logic       csn_rise;
    logic [7:0] byte_in;
    logic       byte_end;
    logic [7:0] status;

    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign csn_s    = csn_q[1];
    assign csn_rise = csn_q[1] & ~csn_q[2];
    assign byte_in  = {shin_q[6:0], mosi_q[1]};
    assign byte_end = (bitpos_q == 3'd7);
    assign status   = {6'b0, wel_q, wip_q};

    assign miso    = ((state_q == STAT) || (state_q == RD)) ? out_q[7] : 1'b0;
    assign miso_oe = ~csn_s;
    assign wip     = wip_q;
    assign wel     = wel_q;

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        bitpos_d = bitpos_q;
        shin_d   = shin_q;
        out_d    = out_q;
        addr_d   = addr_q;
        paddr_d  = paddr_q;
        pdata_d  = pdata_q;
        rd_d     = rd_q;
        wren_d   = wren_q;
        skip_d   = skip_q;
        reload_d = reload_q;
        wel_d    = wel_q;
        wip_d    = wip_q;
        busy_d   = busy_q;
        mem_we   = 1'b0;

        if (wip_q) begin
            if (busy_q == BW'(1)) begin
                busy_d = '0;
                wip_d  = 1'b0;
                wel_d  = 1'b0;
            end else begin
                busy_d = busy_q - BW'(1);
            end
        end

        if (csn_rise) begin
            // Deselect wins over any sck edge seen in the same cycle.
            state_d  = IDLE;
            bitcnt_d = '0;
            bitpos_d = '0;
            skip_d   = 1'b0;
            reload_d = 1'b0;
            if (state_q == WAIT_CS && bitcnt_q == 5'd8 && !wip_q) begin
                wel_d = wren_q;
            end
            if (state_q == WR && bitcnt_q == 5'd24 && wel_q && !wip_q) begin
                mem_we = 1'b1;
                wip_d  = 1'b1;
                busy_d = BW'(WRITE_CYCLES);
            end
        end else if (csn_s) begin
            state_d  = IDLE;
            bitcnt_d = '0;
            bitpos_d = '0;
        end else if (state_q == IDLE) begin
            state_d  = CMD;
            bitcnt_d = '0;
            bitpos_d = '0;
            skip_d   = 1'b0;
            reload_d = 1'b0;
        end else if (sck_rise) begin
            shin_d   = byte_in;
            bitpos_d = bitpos_q + 3'd1;
            if (bitcnt_q != 5'd31) begin
                bitcnt_d = bitcnt_q + 5'd1;
            end
            if (byte_end) begin
                case (state_q)
                    CMD: begin
                        if (wip_q && byte_in != OP_RDSR) begin
                            state_d = IGNORE;
                        end else begin
                            unique case (1'b1)
                                (byte_in == OP_WREN): begin
                                    state_d = WAIT_CS;
                                    wren_d  = 1'b1;
                                end
                                (byte_in == OP_WRDI): begin
                                    state_d = WAIT_CS;
                                    wren_d  = 1'b0;
                                end
                                (byte_in == OP_RDSR): begin
                                    state_d = STAT;
                                    out_d   = status;
                                    skip_d  = 1'b1;
                                end
                                (byte_in == OP_READ): begin
                                    state_d = ADDR;
                                    rd_d    = 1'b1;
                                end
                                (byte_in == OP_WRITE): begin
                                    state_d = ADDR;
                                    rd_d    = 1'b0;
                                end
                                default: state_d = IGNORE;
                            endcase
                        end
                    end
                    ADDR: begin
                        if (rd_q) begin
                            state_d = RD;
                            out_d   = mem[byte_in[ADDR_W-1:0]];
                            addr_d  = byte_in[ADDR_W-1:0] + ADDR_W'(1);
                            skip_d  = 1'b1;
                        end else begin
                            state_d = WR;
                            paddr_d = byte_in[ADDR_W-1:0];
                        end
                    end
                    WR: begin
                        // Only the first data byte is kept.
                        if (bitcnt_q == 5'd23) begin
                            pdata_d = byte_in;
                        end
                    end
                    RD, STAT: reload_d = 1'b1;
                    default: ;
                endcase
            end
        end else if (sck_fall) begin
            // The fall right after a fresh load keeps the MSB on the wire.
            if (skip_q) begin
                skip_d = 1'b0;
            end else if (reload_q) begin
                reload_d = 1'b0;
                if (state_q == STAT) begin
                    out_d = status;
                end else begin
                    out_d  = mem[addr_q];
                    addr_d = addr_q + ADDR_W'(1);
                end
            end else begin
                out_d = {out_q[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_q    <= '0;
            csn_q    <= '1;
            mosi_q   <= '0;
            state_q  <= IDLE;
            bitcnt_q <= '0;
            bitpos_q <= '0;
            shin_q   <= '0;
            out_q    <= '0;
            addr_q   <= '0;
            paddr_q  <= '0;
            pdata_q  <= '0;
            rd_q     <= 1'b0;
            wren_q   <= 1'b0;
            skip_q   <= 1'b0;
            reload_q <= 1'b0;
            wel_q    <= 1'b0;
            wip_q    <= 1'b0;
            busy_q   <= '0;
        end else begin
            sck_q    <= {sck_q[1:0], sck};
            csn_q    <= {csn_q[1:0], csn};
            mosi_q   <= {mosi_q[0], mosi};
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            bitpos_q <= bitpos_d;
            shin_q   <= shin_d;
            out_q    <= out_d;
            addr_q   <= addr_d;
            paddr_q  <= paddr_d;
            pdata_q  <= pdata_d;
            rd_q     <= rd_d;
            wren_q   <= wren_d;
            skip_q   <= skip_d;
            reload_q <= reload_d;
            wel_q    <= wel_d;
            wip_q    <= wip_d;
            busy_q   <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[paddr_q] <= pdata_q;
        end
    end

endmodule

// File: tb/tb_spi_eeprom_slave.sv
// tb_spi_eeprom_slave: directed bench for spi_eeprom_slave.
// Drives SPI mode-0 transfers at clk/10 and checks status, memory and MISO.
module tb_spi_eeprom_slave;
    localparam int WC = 1500;

    logic clk = 1'b0;
    logic rst;
    logic sck;
    logic csn;
    logic mosi;
    logic miso;
    logic miso_oe;
    logic wip;
    logic wel;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spi_eeprom_slave #(
        .ADDR_W      (7),
        .WRITE_CYCLES(WC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sck    (sck),
        .csn    (csn),
        .mosi   (mosi),
        .miso   (miso),
        .miso_oe(miso_oe),
        .wip    (wip),
        .wel    (wel)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_on;
        csn = 1'b0;
        tick(8);
    endtask

    task automatic cs_off;
        tick(5);
        csn = 1'b1;
        tick(12);
    endtask

    // MISO is sampled just before each rising sck edge.
    task automatic xfer(input int n, input logic [31:0] tx,
                        output logic [31:0] rx);
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = tx[i];
            tick(5);
            rx  = {rx[30:0], miso};
            sck = 1'b1;
            tick(5);
            sck = 1'b0;
        end
    endtask

    task automatic txn(input int n, input logic [31:0] tx,
                       output logic [31:0] rx);
        cs_on();
        xfer(n, tx, rx);
        cs_off();
    endtask

    task automatic wait_wip_low;
        int k;
        k = 0;
        while (wip && k < 5000) begin
            tick(1);
            k++;
        end
        check("wip_timeout", {31'b0, wip}, 32'd0);
    endtask

    task automatic wr_byte(input logic [7:0] a, input logic [7:0] d);
        logic [31:0] rx;
        txn(8, 32'h06, rx);
        txn(24, {8'h00, 8'h02, a, d}, rx);
        wait_wip_low();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rx;
        int k;
        int cnt;

        rst  = 1'b1;
        sck  = 1'b0;
        csn  = 1'b1;
        mosi = 1'b0;
        tick(5);
        check("rst_miso", miso, 0);
        check("rst_oe", miso_oe, 0);
        check("rst_wip", wip, 0);
        check("rst_wel", wel, 0);
        rst = 1'b0;
        tick(5);

        txn(16, 32'h0500, rx);
        check("rdsr_init", rx[7:0], 8'h00);
        txn(8, 32'h06, rx);
        check("wren_wel", wel, 1);
        txn(16, 32'h0500, rx);
        check("rdsr_wel", rx[7:0], 8'h02);

        cs_on();
        xfer(24, 32'h02052A, rx);
        check("oe_sel", miso_oe, 1);
        tick(5);
        csn = 1'b1;
        k = 0;
        while (!wip && k < 50) begin
            tick(1);
            k++;
        end
        check("wip_rise", wip, 1);
        cnt = 0;
        while (wip && cnt < 5000) begin
            tick(1);
            cnt++;
        end
        check("wip_len", cnt, WC);
        check("wel_clr", wel, 0);
        tick(10);
        txn(24, 32'h030500, rx);
        check("read_05", rx[7:0], 8'h2A);

        wr_byte(8'h10, 8'h11);
        txn(24, 32'h021055, rx);
        check("nowel_wip", wip, 0);
        txn(16, 32'h0500, rx);
        check("nowel_rdsr", rx[7:0], 8'h00);
        txn(24, 32'h031000, rx);
        check("nowel_mem", rx[7:0], 8'h11);

        wr_byte(8'h7F, 8'hA1);
        wr_byte(8'h00, 8'hB2);
        txn(32, 32'h037F0000, rx);
        check("wrap_7f", rx[15:8], 8'hA1);
        check("wrap_00", rx[7:0], 8'hB2);

        txn(8, 32'h06, rx);
        txn(20, 32'h02057, rx);
        check("part_wip", wip, 0);
        check("part_wel", wel, 1);
        txn(16, 32'h0500, rx);
        check("part_rdsr", rx[7:0], 8'h02);
        txn(24, 32'h030500, rx);
        check("part_mem", rx[7:0], 8'h2A);

        txn(24, 32'h02203C, rx);
        txn(32, 32'h05000000, rx);
        check("busy_rdsr", rx[23:0], 24'h030303);
        txn(24, 32'h030500, rx);
        check("busy_read", rx[23:0], 24'h000000);
        txn(24, 32'h020577, rx);
        txn(8, 32'h06, rx);
        check("busy_held", wip, 1);
        wait_wip_low();
        check("busy_wel", wel, 0);
        txn(24, 32'h030500, rx);
        check("busy_nowr", rx[7:0], 8'h2A);
        txn(24, 32'h032000, rx);
        check("busy_commit", rx[7:0], 8'h3C);

        txn(8, 32'h06, rx);
        check("pre_rst_wel", wel, 1);
        cs_on();
        xfer(12, 32'h032, rx);
        rst = 1'b1;
        tick(3);
        check("mrst_miso", miso, 0);
        check("mrst_oe", miso_oe, 0);
        check("mrst_wel", wel, 0);
        check("mrst_wip", wip, 0);
        rst = 1'b0;
        tick(6);
        check("mrst_oe_on", miso_oe, 1);
        cs_off();
        check("mrst_oe_off", miso_oe, 0);
        txn(24, 32'h032000, rx);
        check("mrst_read", rx[7:0], 8'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
